// File: rtl/serial_run_length_encoder.sv
// Serial run-length encoder: packs an accepted bit stream into {bit, length}
// records and buffers them in a small FIFO behind a valid/ready interface.
module serial_run_length_encoder #(
    parameter int LEN_W = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_bit,
    input  logic                     flush,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_bit,
    output logic [LEN_W-1:0]         out_len,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = LEN_W + 1;

    localparam logic [LEN_W-1:0] MAX_LEN  = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0] LVL_ONE  = {{(LVL_W-1){1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [REC_W-1:0] REC_ZERO = {REC_W{1'b0}};

    logic                 run_active_r, run_active_nxt_s;
    logic                 run_bit_r, run_bit_nxt_s;
    logic [LEN_W-1:0]     run_len_r, run_len_nxt_s;
    logic                 flush_pending_r, flush_pending_nxt_s;

    logic [REC_W-1:0]     mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [LVL_W-1:0]     level_r;

    logic                 full_s, empty_s, in_ready_s;
    logic                 accept_s, flush_acc_s, pop_s;
    logic                 push_s;
    logic [REC_W-1:0]     push_rec_s;

    assign full_s      = (level_r == LVL_FULL);
    assign empty_s     = (level_r == LVL_ZERO);
    assign in_ready_s  = !full_s && !flush_pending_r;
    assign accept_s    = in_valid && in_ready_s;
    assign flush_acc_s = flush && in_ready_s;
    assign pop_s       = !empty_s && out_ready;

    // Run tracking and record generation; at most one push per cycle.
    always_comb begin
        run_active_nxt_s    = run_active_r;
        run_bit_nxt_s       = run_bit_r;
        run_len_nxt_s       = run_len_r;
        flush_pending_nxt_s = flush_pending_r;
        push_s              = 1'b0;
        push_rec_s          = {run_bit_r, run_len_r};

        if (flush_pending_r) begin
            // The held 1-long run is closed once the FIFO has a free slot.
            if (!full_s || pop_s) begin
                push_s              = 1'b1;
                push_rec_s          = {run_bit_r, run_len_r};
                run_active_nxt_s    = 1'b0;
                run_len_nxt_s       = LEN_ZERO;
                flush_pending_nxt_s = 1'b0;
            end else begin
                flush_pending_nxt_s = 1'b1;
            end
        end else if (accept_s) begin
            if (!run_active_r) begin
                if (flush_acc_s) begin
                    push_s           = 1'b1;
                    push_rec_s       = {in_bit, LEN_ONE};
                    run_active_nxt_s = 1'b0;
                    run_len_nxt_s    = LEN_ZERO;
                end else begin
                    run_active_nxt_s = 1'b1;
                    run_bit_nxt_s    = in_bit;
                    run_len_nxt_s    = LEN_ONE;
                end
            end else if ((in_bit == run_bit_r) && (run_len_r != MAX_LEN)) begin
                if (flush_acc_s) begin
                    push_s           = 1'b1;
                    push_rec_s       = {run_bit_r, run_len_r + LEN_ONE};
                    run_active_nxt_s = 1'b0;
                    run_len_nxt_s    = LEN_ZERO;
                end else begin
                    run_len_nxt_s    = run_len_r + LEN_ONE;
                end
            end else begin
                push_s              = 1'b1;
                push_rec_s          = {run_bit_r, run_len_r};
                run_active_nxt_s    = 1'b1;
                run_bit_nxt_s       = in_bit;
                run_len_nxt_s       = LEN_ONE;
                flush_pending_nxt_s = flush_acc_s;
            end
        end else if (flush_acc_s && run_active_r) begin
            push_s           = 1'b1;
            push_rec_s       = {run_bit_r, run_len_r};
            run_active_nxt_s = 1'b0;
            run_len_nxt_s    = LEN_ZERO;
        end else begin
            push_s = 1'b0;
        end
    end

    // Open-run and flush state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_active_r    <= 1'b0;
            run_bit_r       <= 1'b0;
            run_len_r       <= LEN_ZERO;
            flush_pending_r <= 1'b0;
        end else begin
            run_active_r    <= run_active_nxt_s;
            run_bit_r       <= run_bit_nxt_s;
            run_len_r       <= run_len_nxt_s;
            flush_pending_r <= flush_pending_nxt_s;
        end
    end

    // Record FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= REC_ZERO;
            end
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_rec_s;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

    // Head record is forced to zero while the FIFO is empty.
    always_comb begin
        out_valid = !empty_s;
        if (!empty_s) begin
            out_bit = mem_r[rd_ptr_r][LEN_W];
            out_len = mem_r[rd_ptr_r][LEN_W-1:0];
        end else begin
            out_bit = 1'b0;
            out_len = LEN_ZERO;
        end
    end

    assign in_ready   = in_ready_s;
    assign fifo_level = level_r;

endmodule

// File: tb/tb_serial_run_length_encoder.sv
// Directed bench for serial_run_length_encoder: a record-queue model is checked
// every cycle, and hand-computed record lists pin each scenario.
module tb_serial_run_length_encoder;

    localparam int LEN_W   = 4;
    localparam int DEPTH   = 4;
    localparam int MAX_LEN = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_bit, flush, out_ready;
    logic       in_ready, out_valid, out_bit;
    logic [3:0] out_len;
    logic [2:0] fifo_level;

    serial_run_length_encoder #(.LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_bit(out_bit), .out_len(out_len),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: buffered records as bit*100+len, plus the open run.
    int q[$];
    int popped[$];
    bit m_act, m_pend;
    int m_bit, m_len;
    int acc_bits, out_sum, max_level;
    bit ordy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rec(input string name, input int idx, input int exp);
        chk(name, (idx < popped.size()) ? popped[idx] : -1, exp);
    endtask

    task automatic model_reset();
        q.delete();
        popped.delete();
        m_act = 0; m_pend = 0; m_bit = 0; m_len = 0;
        acc_bits = 0; out_sum = 0; max_level = 0;
    endtask

    // One clock: drive after negedge, predict, check outputs at the next negedge.
    task automatic step(input bit v, input bit b, input bit f, output bit acc);
        bit mr, facc, pop, do_push;
        int rec;
        in_valid = v; in_bit = b; flush = f; out_ready = ordy;
        #1;
        mr = (q.size() < DEPTH) && !m_pend;
        chk("in_ready", in_ready, mr);
        acc  = v && mr;
        facc = f && mr;
        pop  = (q.size() > 0) && ordy;
        do_push = 0; rec = 0;
        if (m_pend) begin
            if (q.size() < DEPTH || pop) begin
                do_push = 1; rec = m_bit * 100 + m_len;
                m_pend = 0; m_act = 0;
            end
        end else if (acc) begin
            acc_bits++;
            if (m_act && b == m_bit && m_len < MAX_LEN) begin
                m_len++;
                if (facc) begin do_push = 1; rec = m_bit * 100 + m_len; m_act = 0; end
            end else if (!m_act) begin
                m_act = 1; m_bit = b; m_len = 1;
                if (facc) begin do_push = 1; rec = m_bit * 100 + 1; m_act = 0; end
            end else begin
                do_push = 1; rec = m_bit * 100 + m_len;
                m_bit = b; m_len = 1;
                if (facc) m_pend = 1;
            end
        end else if (facc && m_act) begin
            do_push = 1; rec = m_bit * 100 + m_len; m_act = 0;
        end
        @(posedge clk);
        if (pop) begin
            popped.push_back(q[0]);
            out_sum += q[0] % 100;
            void'(q.pop_front());
        end
        if (do_push) q.push_back(rec);
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_bit", out_bit, (q.size() > 0) ? q[0] / 100 : 0);
        chk("out_len", out_len, (q.size() > 0) ? q[0] % 100 : 0);
        chk("fifo_level", fifo_level, q.size());
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    endtask

    // Source holds the bit until it is accepted, with a bounded wait.
    task automatic send(input bit b, input bit f);
        bit acc;
        int n = 0;
        do begin
            step(1'b1, b, f, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: got 0 accepted, expected 1");
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
        ordy = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_len", out_len, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Alternating pairs, flush with the last bit
        ordy = 1'b1;
        send(1, 0); send(1, 0); send(0, 0); send(0, 0); send(1, 0); send(1, 1);
        idle(3);
        chk("t1_count", popped.size(), 3);
        chk_rec("t1_r0", 0, 102); chk_rec("t1_r1", 1, 2); chk_rec("t1_r2", 2, 102);

        // Saturation split of a 20-long run
        popped.delete(); max_level = 0;
        for (int i = 0; i < 19; i++) send(1, 0);
        send(1, 1);
        idle(3);
        chk("t2_count", popped.size(), 2);
        chk_rec("t2_r0", 0, 115); chk_rec("t2_r1", 1, 105);
        chk("t2_max_level", max_level, 1);

        // Backpressure until full, then drain
        popped.delete(); ordy = 1'b0;
        send(0, 0); send(1, 0); send(0, 0); send(1, 0); send(0, 0);
        chk("t3_level_full", fifo_level, 4);
        chk("t3_ready_low", in_ready, 0);
        step(1'b1, 1'b1, 1'b0, acc);
        chk("t3_held", acc, 0);
        ordy = 1'b1;
        send(1, 0);
        step(1'b0, 1'b0, 1'b1, acc);
        idle(6);
        chk("t3_count", popped.size(), 6);
        chk_rec("t3_r0", 0, 1);   chk_rec("t3_r1", 1, 101);
        chk_rec("t3_r2", 2, 1);   chk_rec("t3_r3", 3, 101);
        chk_rec("t3_r4", 4, 1);   chk_rec("t3_r5", 5, 101);
        chk("t3_ready_back", in_ready, 1);

        // Flush with a bit that itself pushes
        popped.delete();
        send(1, 0); send(1, 0); send(1, 0); send(0, 1);
        chk("t4_pending_ready", in_ready, 0);
        idle(1);
        chk("t4_ready_again", in_ready, 1);
        idle(3);
        chk("t4_count", popped.size(), 2);
        chk_rec("t4_r0", 0, 103); chk_rec("t4_r1", 1, 1);

        // Flush alone with no open run
        popped.delete();
        step(1'b0, 1'b0, 1'b1, acc);
        chk("t5_level", fifo_level, 0);
        idle(2);
        chk("t5_count", popped.size(), 0);
        chk("sum_before_reset", out_sum, acc_bits);

        // Reset mid-operation with two records buffered and a run open
        ordy = 1'b0;
        send(1, 0); send(0, 0); send(1, 0); send(1, 0); send(1, 0);
        chk("t6_level_pre", fifo_level, 2);
        in_valid = 1'b0; flush = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_fifo_level", fifo_level, 0);
        chk("t6_rst_in_ready", in_ready, 1);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        ordy = 1'b1;
        send(0, 0); send(0, 0);
        step(1'b0, 1'b0, 1'b1, acc);
        idle(3);
        chk("t6_count", popped.size(), 1);
        chk_rec("t6_r0", 0, 2);
        chk("t6_sum", out_sum, acc_bits);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
